// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM.
// Port 0 is the CPU data port, port 1 the host/loader or debug port.
// Ownership is registered and round-robin; an owner holding lockX keeps the RAM
// for up to MAX_BURST transfers while the other port waits.
//
// Ports:
//   clk, n_reset                       clock (rising edge), async active-low reset
//   reqX/weX/addrX/wdataX/lockX        requester X command (X = 0, 1)
//   gntX                               transfer of port X executes this cycle
//   rdataX/rvalidX                     registered read data, one-cycle valid pulse
//   mem_addr/mem_wdata/mem_we          RAM drive
//   mem_rdata                          RAM combinational read data
//   owner                              00 idle, 01 port 0, 10 port 1
module ram_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BurstLast = BW'(MAX_BURST - 1);

  // Encoding doubles as the owner output.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;        // 0: favour port 0, 1: favour port 1
  logic [BW-1:0]   burst_q, burst_d;  // transfers already granted under lock
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;

  // Grants and RAM drive
  always_comb begin
    gnt0      = (state_q == StOwn0) && req0;
    gnt1      = (state_q == StOwn1) && req1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (state_q)
      StOwn0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_we    = gnt0 && we0;
      end
      StOwn1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_we    = gnt1 && we1;
      end
      default: ;
    endcase
  end

  // Ownership next state
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = rr_q ? StOwn1 : StOwn0;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          state_d = req1 ? StOwn1 : StIdle;
          burst_d = '0;
        end else if (!req1) begin
          burst_d = '0;
        end else if (lock0 && (burst_q < BurstLast)) begin
          burst_d = burst_q + 1'b1;
        end else begin
          // Lock is ignored once the burst limit is reached.
          state_d = StOwn1;
          burst_d = '0;
        end
      end
      StOwn1: begin
        if (!req1) begin
          state_d = req0 ? StOwn0 : StIdle;
          burst_d = '0;
        end else if (!req0) begin
          burst_d = '0;
        end else if (lock1 && (burst_q < BurstLast)) begin
          burst_d = burst_q + 1'b1;
        end else begin
          state_d = StOwn0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        burst_d = '0;
      end
    endcase
    // Each fresh entry hands priority to the other port for the next contention.
    if ((state_d == StOwn0) && (state_q != StOwn0)) rr_d = 1'b1;
    if ((state_d == StOwn1) && (state_q != StOwn1)) rr_d = 1'b0;
  end

  // Read return
  always_comb begin
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= StIdle;
      rr_q      <= 1'b0;
      burst_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      burst_q   <= burst_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign owner   = state_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small behavioural RAM behind it.
module tb_ram_arbiter;

  logic        clk;
  logic        n_reset;
  logic        req0, we0, lock0, gnt0, rvalid0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        req1, we1, lock1, gnt1, rvalid1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  owner;

  logic [31:0] ram [0:255];
  int          checks = 0;
  int          errors = 0;
  logic        cpu_done;

  ram_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .lock0    (lock0),
    .gnt0     (gnt0),
    .rdata0   (rdata0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .lock1    (lock1),
    .gnt1     (gnt1),
    .rdata1   (rdata1),
    .rvalid1  (rvalid1),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .owner    (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p0_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    int n = 0;
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    #1;
    while (!gnt0 && n < 50) begin
      tick();
      n++;
    end
    chk("p0_grant_timeout", 32'(n < 50), 1);
    tick();
    req0 = 1'b0;
    chk("p0_rvalid", 32'(rvalid0), 32'(!w));
    q = rdata0;
  endtask

  task automatic p1_read(input logic [31:0] a, output logic [31:0] q);
    int n = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a;
    #1;
    while (!gnt1 && n < 50) begin
      tick();
      n++;
    end
    chk("p1_grant_timeout", 32'(n < 50), 1);
    tick();
    req1 = 1'b0;
    chk("p1_rvalid", 32'(rvalid1), 1);
    q = rdata1;
  endtask

  initial begin
    logic [31:0] a, b, d, q;
    int n0, n1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; lock0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; lock1 = 0;
    cpu_done = 1'b0;
    n_reset = 1'b1;
    #1 n_reset = 1'b0;
    #1;
    chk("rst_owner", 32'(owner), 0);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_mem_addr", mem_addr, 0);
    tick();
    tick();

    // 1. Reset mid-transfer, then first grant one cycle after release
    n_reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'hAA;
    #1 chk("t1_gnt0_idle", 32'(gnt0), 0);
    tick();
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_mem_we", 32'(mem_we), 1);
    #2 n_reset = 1'b0;
    #1;
    chk("t1_rst_mem_we", 32'(mem_we), 0);
    chk("t1_rst_gnt0", 32'(gnt0), 0);
    chk("t1_rst_gnt1", 32'(gnt1), 0);
    chk("t1_rst_owner", 32'(owner), 0);
    tick();
    n_reset = 1'b1;
    #1 chk("t1_rel_gnt0", 32'(gnt0), 0);
    tick();
    chk("t1_first_gnt0", 32'(gnt0), 1);
    chk("t1_first_owner", 32'(owner), 1);
    req0 = 1'b0;
    tick();

    // 2. Port 0 write then read back
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd8; wdata0 = 32'h37;
    #1 chk("t2_gnt_latency", 32'(gnt0), 0);
    tick();
    chk("t2_gnt0", 32'(gnt0), 1);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_addr", mem_addr, 32'd8);
    chk("t2_mem_wdata", mem_wdata, 32'h37);
    tick();
    chk("t2_ram8", ram[8], 32'h37);
    chk("t2_no_rvalid_wr", 32'(rvalid0), 0);
    we0 = 1'b0;
    #1 chk("t2_rd_mem_we", 32'(mem_we), 0);
    tick();
    chk("t2_rvalid0", 32'(rvalid0), 1);
    chk("t2_rdata0", rdata0, 32'h37);
    req0 = 1'b0;
    tick();
    chk("t2_rvalid0_pulse", 32'(rvalid0), 0);
    chk("t2_rdata0_hold", rdata0, 32'h37);
    chk("t2_owner_idle", 32'(owner), 0);

    // 3. Contention without lock, from a fresh round-robin pointer
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    n0 = 0; n1 = 0;
    req0 = 1; we0 = 1; addr0 = 32'd16; wdata0 = 32'h100;
    req1 = 1; we1 = 1; addr1 = 32'd32; wdata1 = 32'h200;
    tick();
    for (int c = 0; c < 12; c++) begin
      chk("t3_gnt0", 32'(gnt0), 32'(c % 2 == 0));
      chk("t3_gnt1", 32'(gnt1), 32'(c % 2 == 1));
      chk("t3_owner", 32'(owner), (c % 2 == 0) ? 1 : 2);
      tick();
      if (c % 2 == 0) begin
        n0++; addr0 = 32'(16 + n0); wdata0 = 32'(32'h100 + n0);
        if (n0 == 6) req0 = 1'b0;
      end else begin
        n1++; addr1 = 32'(32 + n1); wdata1 = 32'(32'h200 + n1);
        if (n1 == 6) req1 = 1'b0;
      end
    end
    chk("t3_ram21", ram[21], 32'h105);
    chk("t3_ram37", ram[37], 32'h205);
    tick();
    chk("t3_idle", 32'(owner), 0);

    // 4. Burst lock on port 1
    req1 = 1; lock1 = 1; we1 = 0; addr1 = 32'd8;
    tick();
    req0 = 1; we0 = 0; addr0 = 32'd8;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_burst_gnt1", 32'(gnt1), 1);
      chk("t4_burst_gnt0", 32'(gnt0), 0);
      tick();
      chk("t4_rvalid1", 32'(rvalid1), 1);
      chk("t4_rdata1", rdata1, 32'h37);
    end
    chk("t4_handover_gnt0", 32'(gnt0), 1);
    chk("t4_handover_gnt1", 32'(gnt1), 0);
    tick();
    chk("t4_rvalid0", 32'(rvalid0), 1);
    chk("t4_rdata0", rdata0, 32'h37);
    req0 = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("t4_lock_alone", 32'(gnt1), 1);
      tick();
    end
    chk("t4_owner", 32'(owner), 2);

    // 5. Owner drops its request
    req1 = 0; lock1 = 0; req0 = 1;
    #1;
    chk("t5_drop_gnt1", 32'(gnt1), 0);
    chk("t5_drop_owner", 32'(owner), 2);
    tick();
    chk("t5_switch_owner", 32'(owner), 1);
    chk("t5_switch_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    tick();
    chk("t5_idle0", 32'(owner), 0);
    req1 = 1'b1;
    tick();
    chk("t5_own1", 32'(owner), 2);
    chk("t5_gnt1", 32'(gnt1), 1);
    req1 = 1'b0;
    tick();
    chk("t5_idle1", 32'(owner), 0);
    chk("t5_no_rvalid1", 32'(rvalid1), 0);

    // 6. fib(10) through port 0 while port 1 polls addr 0
    p0_xfer(1'b1, 32'd0, 32'd0, d);
    p0_xfer(1'b1, 32'd1, 32'd0, d);
    p0_xfer(1'b1, 32'd2, 32'd1, d);
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          p0_xfer(1'b0, 32'd1, 32'd0, a);
          p0_xfer(1'b0, 32'd2, 32'd0, b);
          p0_xfer(1'b1, 32'd1, b, d);
          p0_xfer(1'b1, 32'd2, a + b, d);
        end
        p0_xfer(1'b0, 32'd2, 32'd0, b);
        p0_xfer(1'b1, 32'd0, b, d);
        cpu_done = 1'b1;
      end
      begin
        while (!cpu_done) begin
          p1_read(32'd0, q);
          repeat (2) @(posedge clk);
          #1;
        end
      end
    join
    chk("t6_fib_reg", b, 32'd55);
    chk("t6_ram0", ram[0], 32'd55);
    p1_read(32'd0, q);
    chk("t6_p1_rdata", q, 32'd55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
